vectorized_pe_acc: RTL and testbench
====================================

Name: vectorized_pe_acc

Overview:
- Parametrised successor to the SIMD processing element: LANES independent integer lanes with op select NOP/ADD/MUL/MACC, plus a new ACC mode that reduces a stream to one result per packet.
- Adds AXI-Stream-style backpressure through o_tready/i_tready, which the earlier PE lacks.
- Sits between the CGRA stream switch and downstream PEs/reducers.

Parameters:
- LANES, 16, number of SIMD lanes.
- DATA_W, 32, lane width in bits; two's-complement integer.
- OP_W, 3, width of the op select.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i1_data  in  LANES*DATA_W  operand A; lane l occupies bits [l*DATA_W +: DATA_W].
- i2_data  in  LANES*DATA_W  operand B.
- i3_data  in  LANES*DATA_W  operand C (MACC addend only).
- i_tvalid1  in  LANES  per-lane valid for A.
- i_tvalid2  in  LANES  per-lane valid for B.
- i_tlast1  in  LANES  per-lane last for A.
- i_tlast2  in  LANES  per-lane last for B.
- op  in  OP_W  operation select.
- i_tready  out  1  vector-wide ready to both input streams.
- o_data  out  LANES*DATA_W  result.
- o_tvalid  out  LANES  per-lane result valid.
- o_tlast  out  LANES  per-lane result last.
- o_tready  in  1  downstream ready.

Behaviour:
- Reset (rst=0, async): o_data=0, o_tvalid=0, o_tlast=0, all accumulators=0. i_tready=1 from the first cycle after release.
- i_tready = !(|o_tvalid) | o_tready.
- Lane l fires when i_tready & i_tvalid1[l] & i_tvalid2[l]. Lanes with only one operand valid do not fire: no output, accumulator unchanged. The producer must hold that operand.
- Latency: 1 cycle. The result registers on the fire edge. o_tvalid[l]=1 only for lanes that fired and produced an output.
- Output register behaviour:
  - If o_tvalid is nonzero and o_tready=0, o_data, o_tvalid and o_tlast hold. Nothing fires.
  - If o_tready=1 and no lane fires, o_tvalid clears.
- o_tlast[l] = i_tlast1[l] & i_tlast2[l], sampled at fire.
- op encoding (in pe_pkg): NOP=0, ADD=1, MUL=2, MACC=3, ACC=4. Codes 5-7 behave as NOP.
  - NOP: o = A.
  - ADD: o = A+B, mod 2^DATA_W.
  - MUL: o = low DATA_W bits of the signed A*B.
  - MACC: o = A*B + C, mod 2^DATA_W.
  - ACC (no tlast at fire): acc[l] += A*B; no output for that lane.
  - ACC (tlast at fire, i.e. tlast1 & tlast2): o = acc[l] + A*B; o_tvalid[l]=1; acc[l] cleared to 0 on the same edge.
- ACC boundary cases:
  - A single-beat packet (tlast on the first beat) outputs A*B.
  - Accumulation wraps mod 2^DATA_W.
- A fire with op != ACC clears acc[l] for that lane. Switching op mid-packet drops the partial sum.
- op is sampled at fire only. Changing op while stalled has no effect until the next fire.
- Reset asserted mid-packet clears all state immediately. The output is dropped.

Optional Feature:
- SATURATE_EN defined: ADD, MUL, MACC and ACC compute at full precision, then clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. The ACC accumulator saturates on every update.
- Not defined: all arithmetic wraps mod 2^DATA_W, as above.

Decomposition:
- pe_pkg holds:
  - the op enum (NOP, ADD, MUL, MACC, ACC) with OP_W;
  - the default LANES and DATA_W localparams;
  - the saturate-clamp function.
- Sub-module pe_acc_lane: one lane's arithmetic, accumulator and output register, taking the shared fire/stall enables. The top generates LANES instances and computes i_tready.

Test Plan:
- Reset, then ADD with all lanes A=2, B=4, tvalid=FFFF, o_tready=1 -> next cycle o_data lanes=6, o_tvalid=FFFF. MUL on the following beat -> 8.
- MACC with A=3, B=5, C=3 -> 18. With A=6, B=10, C=3 -> 63, with o_tlast=FFFF when both tlasts are high.
- ACC over 3 beats (2*4, 3*5, 6*10, tlast on beat 3) -> o_tvalid=0 on beats 1-2. Beat 3 outputs 83. The next packet of 1*1 with tlast outputs 1 (accumulator cleared).
- Backpressure: o_tready=0 for 4 cycles after an ADD result -> i_tready=0, o_data holds 6. On o_tready=1, the stalled next beat fires exactly once.
- Partial valid: i_tvalid1=FFFF, i_tvalid2=00FF -> only lanes 0-7 output. Lanes 8-15 accumulator unchanged in ACC.
- Wrap vs SATURATE_EN, with DATA_W=32: ADD 0x7FFFFFFF+1 -> 0x80000000 without the macro, 0x7FFFFFFF with it. Reset pulsed mid-ACC packet -> outputs 0, next packet sum starts from 0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the vectorized PE: op encoding, default geometry and
// the saturation clamp used when built with SATURATE_EN.
package pe_pkg;

  localparam int unsigned PE_LANES  = 16;
  localparam int unsigned PE_DATA_W = 32;
  localparam int unsigned PE_OP_W   = 3;
  localparam int unsigned SAT_W     = 128;

  typedef enum logic [PE_OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_ADD  = 3'd1,
    OP_MUL  = 3'd2,
    OP_MACC = 3'd3,
    OP_ACC  = 3'd4
  } op_e;

  // Clamp a full-precision signed value to the w-bit two's-complement range.
  function automatic logic signed [SAT_W-1:0] sat_clamp(
    input logic signed [SAT_W-1:0] x,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi        = '0;
    hi[w-1]   = 1'b1;
    hi        = hi - SAT_W'(1);
    lo        = ~hi;
    if (x > hi)      sat_clamp = hi;
    else if (x < lo) sat_clamp = lo;
    else             sat_clamp = x;
  endfunction

endpackage

// File: rtl/pe_acc_lane.sv
// One SIMD lane: arithmetic, packet accumulator and output register.
// SATURATE_EN selects clamped instead of wrapping arithmetic.
module pe_acc_lane
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = PE_DATA_W,
  parameter int unsigned OP_W   = PE_OP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fire,
  input  logic              advance,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic              last,
  output logic [DATA_W-1:0] o_data,
  output logic              o_tvalid,
  output logic              o_tlast
);

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;
  logic [DATA_W-1:0] r_add;
  logic [DATA_W-1:0] r_mul;
  logic [DATA_W-1:0] r_macc;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] result;
  logic              out_en;

`ifdef SATURATE_EN
  localparam int unsigned WW = 2*DATA_W + 2;
  logic signed [WW-1:0] a_w;
  logic signed [WW-1:0] b_w;
  logic signed [WW-1:0] c_w;
  logic signed [WW-1:0] acc_w;
  logic signed [WW-1:0] prod_w;

  always_comb begin
    a_w    = WW'($signed(a));
    b_w    = WW'($signed(b));
    c_w    = WW'($signed(c));
    acc_w  = WW'($signed(acc));
    prod_w = a_w * b_w;
    r_add  = DATA_W'(sat_clamp(SAT_W'(a_w + b_w), DATA_W));
    r_mul  = DATA_W'(sat_clamp(SAT_W'(prod_w), DATA_W));
    r_macc = DATA_W'(sat_clamp(SAT_W'(prod_w + c_w), DATA_W));
    r_acc  = DATA_W'(sat_clamp(SAT_W'(acc_w + prod_w), DATA_W));
  end
`else
  // Low DATA_W bits of a product are identical for signed and unsigned operands.
  always_comb begin
    r_add  = a + b;
    r_mul  = a * b;
    r_macc = a * b + c;
    r_acc  = acc + a * b;
  end
`endif

  always_comb begin
    result   = a;
    out_en   = 1'b1;
    acc_next = '0;
    case (op)
      OP_ADD:  result = r_add;
      OP_MUL:  result = r_mul;
      OP_MACC: result = r_macc;
      OP_ACC: begin
        result   = r_acc;
        out_en   = last;
        acc_next = last ? '0 : r_acc;
      end
      default: result = a;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_data   <= '0;
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      acc      <= '0;
    end else if (advance) begin
      o_tvalid <= fire & out_en;
      o_tlast  <= fire & out_en & last;
      if (fire && out_en) o_data <= result;
      if (fire)           acc    <= acc_next;
    end
  end

endmodule

// File: rtl/vectorized_pe_acc.sv
// LANES-wide SIMD PE with stream accumulate mode and vector-wide backpressure.
// Define SATURATE_EN for saturating arithmetic.
module vectorized_pe_acc
  import pe_pkg::*;
#(
  parameter int unsigned LANES  = PE_LANES,
  parameter int unsigned DATA_W = PE_DATA_W,
  parameter int unsigned OP_W   = PE_OP_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*DATA_W-1:0] i1_data,
  input  logic [LANES*DATA_W-1:0] i2_data,
  input  logic [LANES*DATA_W-1:0] i3_data,
  input  logic [LANES-1:0]        i_tvalid1,
  input  logic [LANES-1:0]        i_tvalid2,
  input  logic [LANES-1:0]        i_tlast1,
  input  logic [LANES-1:0]        i_tlast2,
  input  logic [OP_W-1:0]         op,
  output logic                    i_tready,
  output logic [LANES*DATA_W-1:0] o_data,
  output logic [LANES-1:0]        o_tvalid,
  output logic [LANES-1:0]        o_tlast,
  input  logic                    o_tready
);

  logic [LANES-1:0] fire;

  // A stalled output freezes every lane, so one ready covers the whole vector.
  assign i_tready = ~(|o_tvalid) | o_tready;
  assign fire     = {LANES{i_tready}} & i_tvalid1 & i_tvalid2;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pe_acc_lane #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .fire     (fire[l]),
      .advance  (i_tready),
      .op       (op),
      .a        (i1_data[l*DATA_W +: DATA_W]),
      .b        (i2_data[l*DATA_W +: DATA_W]),
      .c        (i3_data[l*DATA_W +: DATA_W]),
      .last     (i_tlast1[l] & i_tlast2[l]),
      .o_data   (o_data[l*DATA_W +: DATA_W]),
      .o_tvalid (o_tvalid[l]),
      .o_tlast  (o_tlast[l])
    );
  end

endmodule

// File: tb/tb_vectorized_pe_acc.sv
// Scoreboard bench for vectorized_pe_acc: directed beats push expected results,
// a monitor compares every accepted output transfer.
module tb_vectorized_pe_acc;

  localparam int unsigned LANES = 16;
  localparam int unsigned DW    = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [LANES*DW-1:0]   i1_data = '0;
  logic [LANES*DW-1:0]   i2_data = '0;
  logic [LANES*DW-1:0]   i3_data = '0;
  logic [LANES-1:0]      i_tvalid1 = '0;
  logic [LANES-1:0]      i_tvalid2 = '0;
  logic [LANES-1:0]      i_tlast1 = '0;
  logic [LANES-1:0]      i_tlast2 = '0;
  logic [2:0]            op = '0;
  logic                  i_tready;
  logic [LANES*DW-1:0]   o_data;
  logic [LANES-1:0]      o_tvalid;
  logic [LANES-1:0]      o_tlast;
  logic                  o_tready = 1'b1;

  typedef struct {
    string               name;
    logic [LANES*DW-1:0] data;
    logic [LANES-1:0]    valid;
    logic [LANES-1:0]    last;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  vectorized_pe_acc #(
    .LANES  (LANES),
    .DATA_W (DW),
    .OP_W   (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i1_data   (i1_data),
    .i2_data   (i2_data),
    .i3_data   (i3_data),
    .i_tvalid1 (i_tvalid1),
    .i_tvalid2 (i_tvalid2),
    .i_tlast1  (i_tlast1),
    .i_tlast2  (i_tlast2),
    .op        (op),
    .i_tready  (i_tready),
    .o_data    (o_data),
    .o_tvalid  (o_tvalid),
    .o_tlast   (o_tlast),
    .o_tready  (o_tready)
  );

  always #5 clk = ~clk;

  function automatic logic [LANES*DW-1:0] rep(input logic [DW-1:0] v);
    logic [LANES*DW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*DW +: DW] = v;
    return r;
  endfunction

  task automatic check(input string name, input logic [LANES*DW-1:0] act, input logic [LANES*DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every accepted transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && (|o_tvalid) && o_tready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: o_tvalid=%h o_data=%h, expected no output", o_tvalid, o_data);
      end else begin
        logic bad;
        mon_e = q.pop_front();
        checks++;
        if (o_tvalid !== mon_e.valid) begin
          errors++;
          $display("FAIL %s.tvalid: got %h, expected %h", mon_e.name, o_tvalid, mon_e.valid);
        end
        checks++;
        if (o_tlast !== mon_e.last) begin
          errors++;
          $display("FAIL %s.tlast: got %h, expected %h", mon_e.name, o_tlast, mon_e.last);
        end
        checks++;
        bad = 1'b0;
        for (int l = 0; l < LANES; l++)
          if (mon_e.valid[l] && (o_data[l*DW +: DW] !== mon_e.data[l*DW +: DW])) bad = 1'b1;
        if (bad) begin
          errors++;
          $display("FAIL %s.data: got %h, expected %h", mon_e.name, o_data, mon_e.data);
        end
      end
    end
  end

  // Issue one beat (called just after a rising edge) and return just after its fire edge.
  task automatic send(input string name, input logic [2:0] o,
                      input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                      input logic [LANES-1:0] v1, input logic [LANES-1:0] v2,
                      input logic [LANES-1:0] l1, input logic [LANES-1:0] l2,
                      input logic push, input logic [DW-1:0] exp_lo, input logic [DW-1:0] exp_hi,
                      input logic [LANES-1:0] ev, input logic [LANES-1:0] el);
    exp_t e;
    logic fired;
    op        = o;
    i1_data   = rep(a);
    i2_data   = rep(b);
    i3_data   = rep(c);
    i_tvalid1 = v1;
    i_tvalid2 = v2;
    i_tlast1  = l1;
    i_tlast2  = l2;
    if (push) begin
      e.name  = name;
      e.valid = ev;
      e.last  = el;
      for (int l = 0; l < LANES; l++) e.data[l*DW +: DW] = (l < LANES/2) ? exp_lo : exp_hi;
      q.push_back(e);
    end
    fired = 1'b0;
    for (int n = 0; n < 50 && !fired; n++) begin
      @(negedge clk);
      if (i_tready) fired = 1'b1;
    end
    if (!fired) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: i_tready stayed %b, expected 1 within 50 cycles", name, i_tready);
    end
    @(posedge clk);
    #1;
    i_tvalid1 = '0;
    i_tvalid2 = '0;
    i_tlast1  = '0;
    i_tlast2  = '0;
  endtask

  localparam logic [15:0] ALL = 16'hFFFF;
  localparam logic [15:0] LOW = 16'h00FF;
  localparam logic [15:0] NONE = 16'h0000;

  initial begin
    #1 rst = 1'b0;
    #2;
    check("reset.o_data", o_data, '0);
    check("reset.o_tvalid", {{(LANES*DW-LANES){1'b0}}, o_tvalid}, '0);
    check("reset.o_tlast", {{(LANES*DW-LANES){1'b0}}, o_tlast}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset.i_tready", {{(LANES*DW-1){1'b0}}, i_tready}, 1);

    send("add",   3'd1, 2, 4, 0, ALL, ALL, NONE, NONE, 1,  6,  6, ALL, NONE);
    send("mul",   3'd2, 2, 4, 0, ALL, ALL, NONE, NONE, 1,  8,  8, ALL, NONE);
    send("macc1", 3'd3, 3, 5, 3, ALL, ALL, NONE, NONE, 1, 18, 18, ALL, NONE);
    send("macc2", 3'd3, 6, 10, 3, ALL, ALL, ALL, ALL, 1, 63, 63, ALL, ALL);
    send("macc_half_last", 3'd3, 2, 2, 1, ALL, ALL, ALL, NONE, 1, 5, 5, ALL, NONE);

    send("acc_b1", 3'd4, 2, 4, 0, ALL, ALL, NONE, NONE, 0, 0, 0, NONE, NONE);
    send("acc_b2", 3'd4, 3, 5, 0, ALL, ALL, NONE, NONE, 0, 0, 0, NONE, NONE);
    send("acc_b3", 3'd4, 6, 10, 0, ALL, ALL, ALL, ALL, 1, 83, 83, ALL, ALL);
    send("acc_single", 3'd4, 1, 1, 0, ALL, ALL, ALL, ALL, 1, 1, 1, ALL, ALL);

    // Backpressure: hold the ADD result for 4 cycles while the next beat waits.
    send("add_pre_stall", 3'd1, 2, 4, 0, ALL, ALL, NONE, NONE, 1, 6, 6, ALL, NONE);
    o_tready = 1'b0;
    fork
      send("add_after_stall", 3'd1, 1, 1, 0, ALL, ALL, NONE, NONE, 1, 2, 2, ALL, NONE);
      begin
        repeat (4) begin
          @(negedge clk);
          check("stall.i_tready", {{(LANES*DW-1){1'b0}}, i_tready}, 0);
          check("stall.o_data", o_data, rep(6));
        end
        @(posedge clk);
        #1 o_tready = 1'b1;
      end
    join

    send("add_partial", 3'd1, 5, 7, 0, ALL, LOW, NONE, NONE, 1, 12, 12, LOW, NONE);
    send("acc_partial", 3'd4, 2, 3, 0, ALL, LOW, NONE, NONE, 0, 0, 0, NONE, NONE);
    send("acc_partial_end", 3'd4, 1, 1, 0, ALL, ALL, ALL, ALL, 1, 7, 1, ALL, ALL);

`ifdef SATURATE_EN
    send("add_wrap", 3'd1, 32'h7FFF_FFFF, 1, 0, ALL, ALL, NONE, NONE, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, ALL, NONE);
    send("mul_big", 3'd2, 32'h0001_0000, 32'h0001_0000, 0, ALL, ALL, NONE, NONE, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, ALL, NONE);
`else
    send("add_wrap", 3'd1, 32'h7FFF_FFFF, 1, 0, ALL, ALL, NONE, NONE, 1, 32'h8000_0000, 32'h8000_0000, ALL, NONE);
    send("mul_big", 3'd2, 32'h0001_0000, 32'h0001_0000, 0, ALL, ALL, NONE, NONE, 1, 32'h0, 32'h0, ALL, NONE);
`endif
    send("mul_neg", 3'd2, 32'hFFFF_FFFD, 5, 0, ALL, ALL, NONE, NONE, 1, 32'hFFFF_FFF1, 32'hFFFF_FFF1, ALL, NONE);

    send("acc_wrap_b1", 3'd4, 32'h7FFF_FFFF, 1, 0, ALL, ALL, NONE, NONE, 0, 0, 0, NONE, NONE);
`ifdef SATURATE_EN
    send("acc_wrap_b2", 3'd4, 1, 1, 0, ALL, ALL, ALL, ALL, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, ALL, ALL);
`else
    send("acc_wrap_b2", 3'd4, 1, 1, 0, ALL, ALL, ALL, ALL, 1, 32'h8000_0000, 32'h8000_0000, ALL, ALL);
`endif

    send("switch_acc", 3'd4, 2, 4, 0, ALL, ALL, NONE, NONE, 0, 0, 0, NONE, NONE);
    send("switch_add", 3'd1, 1, 1, 0, ALL, ALL, NONE, NONE, 1, 2, 2, ALL, NONE);
    send("switch_acc_end", 3'd4, 1, 1, 0, ALL, ALL, ALL, ALL, 1, 1, 1, ALL, ALL);

    send("nop", 3'd0, 9, 3, 0, ALL, ALL, NONE, NONE, 1, 9, 9, ALL, NONE);
    send("op5_nop", 3'd5, 11, 3, 0, ALL, ALL, NONE, NONE, 1, 11, 11, ALL, NONE);

    // Reset in the middle of an ACC packet discards the partial sum.
    send("rst_acc_b1", 3'd4, 5, 5, 0, ALL, ALL, NONE, NONE, 0, 0, 0, NONE, NONE);
    rst = 1'b0;
    #2;
    check("midrst.o_data", o_data, '0);
    check("midrst.o_tvalid", {{(LANES*DW-LANES){1'b0}}, o_tvalid}, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    send("rst_acc_next", 3'd4, 1, 2, 0, ALL, ALL, ALL, ALL, 1, 2, 2, ALL, ALL);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", LANES*DW'(q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
